// File: rtl/race_turn_sequencer_if.sv
// Game-logic bus between the turn sequencer (master) and its dice source /
// renderer side (slave).
interface race_turn_sequencer_if;
  logic       dice_valid;
  logic [2:0] dice_value;
  logic       restart;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       winner_valid;
  logic       winner_id;
  logic [3:0] player1_tile;
  logic [3:0] player2_tile;
  logic       busy;
  logic       timeout_err;

  modport master (
    input  dice_valid, dice_value, restart, turn_done,
    output player1_pos_x, player2_pos_x, pos_valid, active_player,
           winner_valid, winner_id, player1_tile, player2_tile, busy, timeout_err
  );

  modport slave (
    output dice_valid, dice_value, restart, turn_done,
    input  player1_pos_x, player2_pos_x, pos_valid, active_player,
           winner_valid, winner_id, player1_tile, player2_tile, busy, timeout_err
  );
endinterface

// File: rtl/race_turn_sequencer.sv
// Two-player race sequencer: applies dice rolls and question-box bonuses,
// hands positions to the renderer and waits for its animation handshake.
module race_turn_sequencer #(
  parameter int                   TILE_X0        = 20,
  parameter int                   TILE_PITCH     = 60,
  parameter int                   FINISH_TILE    = 10,
  parameter logic [FINISH_TILE:0] BONUS_MASK     = 11'b00101010100,
  parameter int                   BONUS_STEPS    = 1,
  parameter int                   TIMEOUT_CYCLES = 75_000_000
) (
  input logic                  clk,
  input logic                  rst,
  race_turn_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, MOVE, WAIT_MOVE, BONUS, WAIT_BONUS, NEXT, WIN} state_t;

  localparam int              CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      FIN      = 4'(FINISH_TILE);

  function automatic logic [9:0] tile_x(input logic [3:0] t);
    return 10'(TILE_X0 + TILE_PITCH * int'(t));
  endfunction

  function automatic logic [3:0] clamp_add(input logic [3:0] t, input logic [3:0] inc);
    logic [4:0] s;
    s = {1'b0, t} + {1'b0, inc};
    return (s >= 5'(FINISH_TILE)) ? FIN : s[3:0];
  endfunction

  state_t          state;
  logic [1:0][3:0] tile_q;
  logic [1:0][9:0] pos_q;
  logic            act, pos_valid_q, win_q, win_id_q, to_err_q;
  logic [CW-1:0]   cnt;
  logic [3:0]      cur, next_move, next_bonus;
  logic            dice_ok, wait_exit;

  assign cur        = tile_q[act];
  assign next_move  = clamp_add(cur, {1'b0, bus.dice_value});
  assign next_bonus = clamp_add(cur, 4'(BONUS_STEPS));
  assign dice_ok    = bus.dice_valid && (bus.dice_value != 3'd0) && (bus.dice_value != 3'd7);
  assign wait_exit  = bus.turn_done || (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tile_q      <= '0;
      pos_q       <= {2{10'(TILE_X0)}};
      act         <= 1'b0;
      pos_valid_q <= 1'b0;
      win_q       <= 1'b0;
      win_id_q    <= 1'b0;
      to_err_q    <= 1'b0;
      cnt         <= '0;
    end else begin
      pos_valid_q <= 1'b0;
      if (bus.restart) begin
        // Renderer gets one pulse to re-sync; timeout_err survives on purpose.
        state       <= IDLE;
        tile_q      <= '0;
        pos_q       <= {2{10'(TILE_X0)}};
        act         <= 1'b0;
        win_q       <= 1'b0;
        cnt         <= '0;
        pos_valid_q <= 1'b1;
      end else begin
        case (state)
          IDLE: if (dice_ok) begin
            tile_q[act] <= next_move;
            pos_q[act]  <= tile_x(next_move);
            pos_valid_q <= 1'b1;
            state       <= MOVE;
          end
          MOVE:  state <= WAIT_MOVE;
          WAIT_MOVE: begin
            cnt <= cnt + 1'b1;
            if (wait_exit) begin
              cnt <= '0;
              if (!bus.turn_done) to_err_q <= 1'b1;
              if (cur == FIN) begin
                win_q    <= 1'b1;
                win_id_q <= act;
                state    <= WIN;
              end else if (BONUS_MASK[cur]) begin
                tile_q[act] <= next_bonus;
                pos_q[act]  <= tile_x(next_bonus);
                pos_valid_q <= 1'b1;
                state       <= BONUS;
              end else begin
                state <= NEXT;
              end
            end
          end
          BONUS: state <= WAIT_BONUS;
          // No bonus check here: at most one bonus per turn.
          WAIT_BONUS: begin
            cnt <= cnt + 1'b1;
            if (wait_exit) begin
              cnt <= '0;
              if (!bus.turn_done) to_err_q <= 1'b1;
              if (cur == FIN) begin
                win_q    <= 1'b1;
                win_id_q <= act;
                state    <= WIN;
              end else begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            act   <= ~act;
            state <= IDLE;
          end
          WIN:     state <= WIN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.player1_pos_x = pos_q[0];
  assign bus.player2_pos_x = pos_q[1];
  assign bus.player1_tile  = tile_q[0];
  assign bus.player2_tile  = tile_q[1];
  assign bus.pos_valid     = pos_valid_q;
  assign bus.active_player = act;
  assign bus.winner_valid  = win_q;
  assign bus.winner_id     = win_id_q;
  assign bus.timeout_err   = to_err_q;
  assign bus.busy          = (state != IDLE) && (state != WIN);
endmodule

// File: tb/tb_race_turn_sequencer.sv
// Directed + randomized game play against a tile/turn reference model.
module tb_race_turn_sequencer;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  race_turn_sequencer_if bus();
  race_turn_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // reference model: game state as plain integers
  int mt[2];
  int ma;
  bit mwin;
  int mwid;
  bit mto;

  function automatic int px(input int t);
    return 20 + 60 * t;
  endfunction

  function automatic bit is_bonus(input int t);
    return (t == 2) || (t == 4) || (t == 6) || (t == 8);
  endfunction

  function automatic int min10(input int t);
    return (t > 10) ? 10 : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".p1_tile"}, 32'(bus.player1_tile), mt[0]);
    chk({tag, ".p2_tile"}, 32'(bus.player2_tile), mt[1]);
    chk({tag, ".p1_x"}, 32'(bus.player1_pos_x), px(mt[0]));
    chk({tag, ".p2_x"}, 32'(bus.player2_pos_x), px(mt[1]));
    chk({tag, ".active"}, 32'(bus.active_player), ma);
    chk({tag, ".winner_valid"}, 32'(bus.winner_valid), 32'(mwin));
    chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(mto));
    if (mwin) chk({tag, ".winner_id"}, 32'(bus.winner_id), mwid);
  endtask

  // Entered on the negedge where pos_valid is high; leaves on the negedge after the wait exits.
  task automatic wait_exit(input string tag, input bit use_to);
    int  d;
    bit  drop;
    bit  early;
    int  k;
    d     = $urandom_range(2, 12);
    drop  = 1'($urandom_range(0, 1));
    early = 1'($urandom_range(0, 1));
    k     = use_to ? TO : d;
    for (int i = 0; i < k; i++) begin
      bus.turn_done  = (i == 0) && early;
      bus.dice_valid = (i == 1) && drop;
      bus.dice_value = 3'($urandom_range(1, 6));
      tick;
      bus.turn_done  = 1'b0;
      bus.dice_valid = 1'b0;
      chk({tag, ".wait_pv"}, 32'(bus.pos_valid), 0);
      chk({tag, ".wait_busy"}, 32'(bus.busy), 1);
    end
    if (!use_to) bus.turn_done = 1'b1;
    tick;
    bus.turn_done = 1'b0;
    if (use_to) mto = 1'b1;
  endtask

  task automatic do_turn(input string tag, input int v, input bit use_to);
    bus.dice_value = 3'(v);
    bus.dice_valid = 1'b1;
    tick;
    bus.dice_valid = 1'b0;
    if (mwin || v < 1 || v > 6) begin
      for (int i = 0; i < 3; i++) begin
        chk({tag, ".ignored_pv"}, 32'(bus.pos_valid), 0);
        tick;
      end
      chk_all({tag, ".ignored"});
      return;
    end
    mt[ma] = min10(mt[ma] + v);
    chk({tag, ".move_pv"}, 32'(bus.pos_valid), 1);
    chk({tag, ".move_busy"}, 32'(bus.busy), 1);
    chk_all({tag, ".move"});
    wait_exit({tag, ".w1"}, use_to);
    if (mt[ma] != 10 && is_bonus(mt[ma])) begin
      mt[ma] = min10(mt[ma] + 1);
      chk({tag, ".bonus_pv"}, 32'(bus.pos_valid), 1);
      chk_all({tag, ".bonus"});
      wait_exit({tag, ".w2"}, use_to);
    end
    if (mt[ma] == 10) begin
      mwin = 1'b1;
      mwid = ma;
      chk_all({tag, ".win"});
      chk({tag, ".win_busy"}, 32'(bus.busy), 0);
      chk({tag, ".win_pv"}, 32'(bus.pos_valid), 0);
      return;
    end
    chk({tag, ".next_busy"}, 32'(bus.busy), 1);
    chk({tag, ".next_pv"}, 32'(bus.pos_valid), 0);
    tick;
    ma ^= 1;
    chk_all({tag, ".idle"});
    chk({tag, ".idle_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic do_restart(input string tag);
    bus.restart    = 1'b1;
    bus.dice_valid = 1'b1;
    bus.dice_value = 3'd4;
    bus.turn_done  = 1'b1;
    tick;
    bus.restart    = 1'b0;
    bus.dice_valid = 1'b0;
    bus.turn_done  = 1'b0;
    mt[0] = 0; mt[1] = 0; ma = 0; mwin = 1'b0;
    chk({tag, ".pv"}, 32'(bus.pos_valid), 1);
    chk({tag, ".busy"}, 32'(bus.busy), 0);
    chk_all(tag);
    tick;
    chk({tag, ".pv_after"}, 32'(bus.pos_valid), 0);
    chk_all({tag, ".after"});
  endtask

  task automatic play_game(input string tag);
    for (int t = 0; t < 60 && !mwin; t++)
      do_turn(tag, $urandom_range(0, 7), $urandom_range(0, 9) == 0);
  endtask

  initial begin
    bus.dice_valid = 1'b0;
    bus.dice_value = 3'd0;
    bus.restart    = 1'b0;
    bus.turn_done  = 1'b0;
    rst = 1'b1;
    mt[0] = 0; mt[1] = 0; ma = 0; mwin = 1'b0; mwid = 0; mto = 1'b0;
    bus.dice_valid = 1'b1;
    bus.dice_value = 3'd5;
    repeat (3) tick;
    bus.dice_valid = 1'b0;
    chk_all("reset");
    chk("reset.pv", 32'(bus.pos_valid), 0);
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.winner_id", 32'(bus.winner_id), 0);
    rst = 1'b0;
    tick;

    do_turn("single", 3, 1'b0);
    do_turn("bonus", 2, 1'b0);
    do_turn("illegal0", 0, 1'b0);
    do_turn("illegal7", 7, 1'b0);
    do_turn("timeout", 1, 1'b1);
    do_turn("after_to", 4, 1'b0);

    play_game("game0");
    do_turn("win_ignore", 3, 1'b0);
    do_restart("restart_win");

    for (int g = 1; g < 4; g++) begin
      play_game("gameN");
      do_restart("restartN");
    end

    // restart while the renderer handshake is outstanding
    bus.dice_value = 3'd5;
    bus.dice_valid = 1'b1;
    tick;
    bus.dice_valid = 1'b0;
    tick;
    do_restart("restart_mid");

    // reset mid-turn returns to reset values with no pulse
    bus.dice_value = 3'd6;
    bus.dice_valid = 1'b1;
    tick;
    bus.dice_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    mt[0] = 0; mt[1] = 0; ma = 0; mwin = 1'b0; mto = 1'b0;
    chk_all("rst_mid");
    chk("rst_mid.pv", 32'(bus.pos_valid), 0);
    chk("rst_mid.busy", 32'(bus.busy), 0);
    rst = 1'b0;
    tick;
    chk("rst_mid.pv_after", 32'(bus.pos_valid), 0);
    do_turn("post_rst", 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/race_turn_sequencer.md
Name: race_turn_sequencer

Overview:
- Turn-based game sequencer that drives the UI renderer's game-logic interface.
- Accepts dice results from the dice-detection path and keeps each player's tile index.
- Converts tiles to screen x, pulses pos_valid, waits for the renderer's turn_done, and applies question-box bonus moves.
- Detects the winner and alternates active_player.
- Sits between the dice recognizer and ui_render.

Parameters:
- TILE_X0, 20: screen x of tile 0.
- TILE_PITCH, 60: x distance between adjacent tiles.
- FINISH_TILE, 10: finish tile index; reaching it wins.
- BONUS_MASK, 11'b00101010100: bit n=1 means tile n holds a question box (tiles 2, 4, 6, 8).
- BONUS_STEPS, 1: extra tiles granted on landing on a bonus tile.
- TIMEOUT_CYCLES, 75_000_000: maximum wait for turn_done (3 s at 25 MHz).

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- dice_valid  in  1  one-cycle pulse: dice_value is valid.
- dice_value  in  3  rolled value; legal values 1..6.
- restart  in  1  one-cycle pulse: start a new game.
- turn_done  in  1  one-cycle pulse from the renderer: animation finished.
- player1_pos_x  out  10  Player 1 target x.
- player2_pos_x  out  10  Player 2 target x.
- pos_valid  out  1  one-cycle position-update pulse.
- active_player  out  1  0=Player1, 1=Player2.
- winner_valid  out  1  game over; level signal.
- winner_id  out  1  winning player; valid while winner_valid=1.
- player1_tile  out  4  Player 1 tile index.
- player2_tile  out  4  Player 2 tile index.
- busy  out  1  high in any state other than IDLE and WIN.
- timeout_err  out  1  sticky: a turn_done wait timed out.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - tiles=0; both pos_x = TILE_X0 (20).
  - pos_valid=0, active_player=0, winner_valid=0, winner_id=0, busy=0, timeout_err=0.
  - State = IDLE; timeout counter = 0.
- pos_x(tile) = TILE_X0 + TILE_PITCH*tile, computed in 10 bits with no overflow (tile 10 gives 620).
- The pos_x outputs are registers. They update on the same edge that raises pos_valid.
- States: IDLE, MOVE, WAIT_MOVE, BONUS, WAIT_BONUS, NEXT, WIN.
- IDLE:
  - dice_valid with dice_value in 1..6: new = min(tile[active]+dice_value, FINISH_TILE). Store new and its pos_x; go to MOVE.
  - dice_value 0 or 7: ignored; stay in IDLE.
- MOVE: pos_valid=1 for exactly this cycle, then WAIT_MOVE.
  - Latency is dice_valid at edge N, pos_valid high during cycle N+1.
- WAIT_MOVE: counter increments each cycle. Exit on turn_done or counter==TIMEOUT_CYCLES-1. A timeout exit sets timeout_err. Counter clears on exit. Next state:
  - tile==FINISH_TILE goes to WIN.
  - BONUS_MASK[tile]=1 goes to BONUS.
  - Otherwise go to NEXT.
- BONUS: tile = min(tile+BONUS_STEPS, FINISH_TILE); pos_x updates; pos_valid=1 for one cycle; go to WAIT_BONUS.
- WAIT_BONUS: same exit and timeout rules as WAIT_MOVE. Next state is WIN if tile==FINISH_TILE, else NEXT.
  - Bonus never chains: at most one bonus per turn, even if the bonus tile is itself a bonus tile.
- NEXT: active_player toggles; go to IDLE. One cycle.
- WIN: winner_valid=1 and winner_id=active_player. active_player holds. dice_valid is ignored.
- turn_done outside WAIT_* states is ignored. This includes a turn_done in the same cycle as pos_valid.
- dice_valid while busy=1 is dropped; there is no queueing.
- restart (any state, priority over dice_valid and turn_done):
  - Next edge: tiles=0, pos_x=TILE_X0, active_player=0, winner_valid=0, counter=0.
  - timeout_err is retained; only rst clears it.
  - pos_valid=1 for one cycle so the renderer re-syncs, then IDLE.
  - No turn_done wait follows a restart.
- Only the active player's tile and pos_x change during a turn; the other player's registers hold.
- rst mid-turn: immediate return to reset values. No pos_valid pulse.

Test Plan:
- Single move: after rst, dice_valid with value 3 → next cycle pos_valid=1, player1_pos_x=200, player1_tile=3. turn_done 5 cycles later → active_player=1 two cycles later; busy low.
- Bonus move: P1 at tile 0, roll 2 → pos_valid with x=140. turn_done → second pos_valid with x=200, tile 3. Second turn_done → NEXT; exactly 2 pos_valid pulses in total.
- Finish clamp and win: P2 at tile 7, roll 6 → tile 10, x=620. turn_done → winner_valid=1, winner_id=1. Later dice_valid is ignored.
- Illegal and busy dice: dice_value 0 in IDLE → no pos_valid. dice_valid during WAIT_MOVE → dropped; tiles unchanged.
- Timeout: TIMEOUT_CYCLES=16, no turn_done → advance 16 cycles after entering WAIT_MOVE; timeout_err=1 and remains set.
- Restart from WIN: restart → one pos_valid with both pos_x=20. winner_valid=0, active_player=0, tiles=0, IDLE.
